axi_addr_decode_slice: RTL and testbench
========================================

Name: axi_addr_decode_slice

Overview:
- Parametrised, registered successor to the crossbar's fixed combinational address decoder.
- Takes an AW/AR request (address plus tag) through a valid/ready handshake. Decodes it against a parameter-defined region table. Presents it downstream through a 2-entry skid buffer with a one-hot slave select and a DECERR flag.
- Sits between each crossbar master port and the arbiter/router. Also keeps a saturating count of decode errors for debug.

Parameters:
- NUM_SLAVES, 8, number of regions/slave ports; width of the select vector.
- ADDR_W, 32, address width.
- TAG_W, 4, width of the opaque tag (AXI ID) carried with each request.
- CNT_W, 16, width of the decode-error counter.
- REGION_BASE, packed NUM_SLAVES*ADDR_W, base of region i in slice [i*ADDR_W +: ADDR_W]. Default (i=7..0): 0x00000000, 0x00008000, 0x00008010, 0x00008020, 0x00008030, 0x00008040, 0x00008050, 0x80000000.
- REGION_SIZE, packed NUM_SLAVES*ADDR_W, byte size of region i. Default (i=7..0): 0x4000, 0x10, 0x10, 0x10, 0x10, 0x10, 0x10, 0x08000000.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  slice can accept a request.
- in_addr  in  ADDR_W  request address.
- in_tag  in  TAG_W  request tag.
- out_valid  out  1  decoded request valid.
- out_ready  in  1  downstream accepts.
- out_addr  out  ADDR_W  registered address.
- out_tag  out  TAG_W  registered tag.
- out_sel  out  NUM_SLAVES  one-hot slave select; bit i = region i. All-zero on DECERR.
- out_decerr  out  1  address hit no region.
- decerr_cnt  out  CNT_W  saturating count of DECERR requests delivered.
- cnt_clr  in  1  synchronous clear of decerr_cnt.

Behaviour:
- Reset (rst=1 at a clock edge):
  - Both buffer entries are emptied.
  - out_valid=0, in_ready=1, out_sel=0, out_decerr=0, out_addr=0, out_tag=0, decerr_cnt=0.
  - Reset mid-transfer drops any held requests without completing them.
- Decode (combinational on in_addr, registered with the entry):
  - Region i hits when REGION_SIZE[i] != 0 and REGION_BASE[i] <= addr < BASE+SIZE.
  - Compare in ADDR_W+1 bits so BASE+SIZE does not wrap; a region ending at 2^ADDR_W is legal.
  - Overlapping hits: the highest index wins, so out_sel is always one-hot.
  - No hit: out_sel=0, out_decerr=1.
- Handshake: transfer on in_valid&in_ready and on out_valid&out_ready. The upstream side holds payload while in_valid&!in_ready.
- Buffer: 2 entries (main and skid), occupancy states EMPTY, ONE, FULL.
  - EMPTY + accept → ONE. Latency is 1 cycle: a request accepted at edge N shows out_valid=1 after edge N.
  - ONE + accept + no drain → FULL.
  - ONE + drain + no accept → EMPTY.
  - ONE + accept + drain → ONE, holding the new request.
  - FULL + drain → ONE; the skid entry moves to the output.
- in_ready is a registered output and is 0 only in FULL. in_ready has no combinational path from out_ready.
- Order is strictly FIFO.
- Full throughput: 1 request/cycle when out_ready is held high.
- Output payload is stable while out_valid&!out_ready.
- decerr_cnt:
  - Increments by 1 on an output handshake with out_decerr=1.
  - Saturates at all-ones.
  - cnt_clr has priority over an increment in the same cycle; the result is 0.
- No X propagation: out_sel and out_decerr are forced to 0 whenever out_valid=0.

Test Plan:
- Default table, single requests 0x00003FFC, 0x00008014, 0x80000000 with out_ready=1 → out_sel 0x80, 0x20, 0x01 respectively, decerr=0, each 1 cycle after acceptance.
- Boundaries: 0x00004000, 0x00008060, 0x88000000, 0xFFFFFFFF → out_sel=0, out_decerr=1. After the 4 handshakes decerr_cnt=4; cnt_clr on the cycle of a 5th DECERR → decerr_cnt=0.
- Back-pressure: out_ready=0, send tags 1,2,3 → first two accepted, in_ready=0 after the 2nd. Release out_ready → tags 1,2,3 delivered in order with payload stable while stalled.
- Streaming: 100 consecutive requests with in_valid=out_ready=1 → 100 outputs in 100 consecutive cycles after the first, order and tags preserved.
- Parameter override: NUM_SLAVES=2, region0 base 0x0 size 0x1000, region1 base 0x800 size 0xFFFFF800 (ends at 2^32) → 0x900 selects 0b10 (overlap, higher index), 0xFFFFFFFF selects 0b10, 0x100 selects 0b01.
- Reset while FULL → next cycle out_valid=0, in_ready=1, decerr_cnt=0; a new request after reset is delivered with no stale data. With CNT_W=2, 5 DECERRs → decerr_cnt=3 (saturated).

Source files
------------

// File: rtl/axi_addr_decode_slice.sv
// ----------------------------------------------------------------------------
// axi_addr_decode_slice
//
// Registered AW/AR address decode stage. It accepts a request (address + tag)
// over a valid/ready handshake and decodes the address against a region
// table set by parameters. The request is then presented downstream through a
// 2-entry (main + skid) buffer, together with a one-hot slave select and a
// DECERR flag. It also keeps a saturating count of DECERR requests delivered
// downstream, for debug.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   in_valid    upstream request valid
//   in_ready    slice can accept (registered, low only when both entries full)
//   in_addr     request address
//   in_tag      opaque request tag (AXI ID)
//   out_valid   decoded request valid
//   out_ready   downstream accepts
//   out_addr    registered address
//   out_tag     registered tag
//   out_sel     one-hot slave select, bit i = region i, zero on DECERR/idle
//   out_decerr  address hit no region (zero when idle)
//   decerr_cnt  saturating count of DECERR requests delivered
//   cnt_clr     synchronous clear of decerr_cnt (wins over an increment)
// ----------------------------------------------------------------------------
module axi_addr_decode_slice #(
    parameter int unsigned NUM_SLAVES = 8,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned TAG_W      = 4,
    parameter int unsigned CNT_W      = 16,
    // Region i occupies slice [i*ADDR_W +: ADDR_W]; listed here from i=7 down to 0.
    parameter logic [NUM_SLAVES*ADDR_W-1:0] REGION_BASE = {
        32'h0000_0000, 32'h0000_8000, 32'h0000_8010, 32'h0000_8020,
        32'h0000_8030, 32'h0000_8040, 32'h0000_8050, 32'h8000_0000},
    parameter logic [NUM_SLAVES*ADDR_W-1:0] REGION_SIZE = {
        32'h0000_4000, 32'h0000_0010, 32'h0000_0010, 32'h0000_0010,
        32'h0000_0010, 32'h0000_0010, 32'h0000_0010, 32'h0800_0000}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_W-1:0]     in_addr,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_W-1:0]     out_addr,
    output logic [TAG_W-1:0]      out_tag,
    output logic [NUM_SLAVES-1:0] out_sel,
    output logic                  out_decerr,
    output logic [CNT_W-1:0]      decerr_cnt,
    input  logic                  cnt_clr
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } occ_e;

    // ------------------------------------------------------------------------
    // Combinational decode of the incoming address
    // ------------------------------------------------------------------------
    logic [NUM_SLAVES-1:0] hit;
    logic [NUM_SLAVES:0]   hit_at_or_above;
    logic [NUM_SLAVES-1:0] dec_sel;
    logic                  dec_err;
    logic [ADDR_W:0]       addr_x;

    // One extra bit so that BASE+SIZE reaching 2^ADDR_W does not wrap.
    assign addr_x = {1'b0, in_addr};

    for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_region
        localparam logic [ADDR_W-1:0] BASE  = REGION_BASE[g*ADDR_W +: ADDR_W];
        localparam logic [ADDR_W-1:0] SIZE  = REGION_SIZE[g*ADDR_W +: ADDR_W];
        localparam logic [ADDR_W:0]   LO_X  = {1'b0, BASE};
        localparam logic [ADDR_W:0]   END_X = {1'b0, BASE} + {1'b0, SIZE};
        localparam bit                USED  = (SIZE != '0);

        assign hit[g] = USED && (addr_x >= LO_X) && (addr_x < END_X);

        // Highest index wins on overlap: region g is selected only when no
        // higher-numbered region also hits.
        assign hit_at_or_above[g] = hit[g] | hit_at_or_above[g+1];
        assign dec_sel[g]         = hit[g] & ~hit_at_or_above[g+1];
    end

    assign hit_at_or_above[NUM_SLAVES] = 1'b0;
    assign dec_err                     = ~hit_at_or_above[0];

    // ------------------------------------------------------------------------
    // Two-entry buffer: main drives the outputs, skid catches the request
    // accepted while main is stalled.
    // ------------------------------------------------------------------------
    occ_e                  state_q, state_d;
    logic                  in_ready_q, in_ready_d;
    logic                  out_valid_q, out_valid_d;

    logic [ADDR_W-1:0]     main_addr_q, main_addr_d;
    logic [TAG_W-1:0]      main_tag_q,  main_tag_d;
    logic [NUM_SLAVES-1:0] main_sel_q,  main_sel_d;
    logic                  main_err_q,  main_err_d;

    logic [ADDR_W-1:0]     skid_addr_q, skid_addr_d;
    logic [TAG_W-1:0]      skid_tag_q,  skid_tag_d;
    logic [NUM_SLAVES-1:0] skid_sel_q,  skid_sel_d;
    logic                  skid_err_q,  skid_err_d;

    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic                  accept;
    logic                  drain;

    assign accept = in_valid & in_ready_q;
    assign drain  = out_valid_q & out_ready;

    always_comb begin
        state_d     = state_q;
        main_addr_d = main_addr_q;
        main_tag_d  = main_tag_q;
        main_sel_d  = main_sel_q;
        main_err_d  = main_err_q;
        skid_addr_d = skid_addr_q;
        skid_tag_d  = skid_tag_q;
        skid_sel_d  = skid_sel_q;
        skid_err_d  = skid_err_q;

        unique case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    main_addr_d = in_addr;
                    main_tag_d  = in_tag;
                    main_sel_d  = dec_sel;
                    main_err_d  = dec_err;
                    state_d     = ST_ONE;
                end
            end
            ST_ONE: begin
                unique case ({accept, drain})
                    2'b10: begin
                        skid_addr_d = in_addr;
                        skid_tag_d  = in_tag;
                        skid_sel_d  = dec_sel;
                        skid_err_d  = dec_err;
                        state_d     = ST_FULL;
                    end
                    2'b01: begin
                        state_d = ST_EMPTY;
                    end
                    2'b11: begin
                        main_addr_d = in_addr;
                        main_tag_d  = in_tag;
                        main_sel_d  = dec_sel;
                        main_err_d  = dec_err;
                    end
                    default: begin
                    end
                endcase
            end
            ST_FULL: begin
                // in_ready is low here, so only a drain can happen.
                if (drain) begin
                    main_addr_d = skid_addr_q;
                    main_tag_d  = skid_tag_q;
                    main_sel_d  = skid_sel_q;
                    main_err_d  = skid_err_q;
                    state_d     = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        // Handshake flags are registered copies of the next occupancy, so
        // in_ready has no combinational path from out_ready.
        in_ready_d  = (state_d != ST_FULL);
        out_valid_d = (state_d != ST_EMPTY);
    end

    // ------------------------------------------------------------------------
    // DECERR counter
    // ------------------------------------------------------------------------
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (drain && main_err_q && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            main_addr_q <= '0;
            main_tag_q  <= '0;
            main_sel_q  <= '0;
            main_err_q  <= 1'b0;
            skid_addr_q <= '0;
            skid_tag_q  <= '0;
            skid_sel_q  <= '0;
            skid_err_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            main_addr_q <= main_addr_d;
            main_tag_q  <= main_tag_d;
            main_sel_q  <= main_sel_d;
            main_err_q  <= main_err_d;
            skid_addr_q <= skid_addr_d;
            skid_tag_q  <= skid_tag_d;
            skid_sel_q  <= skid_sel_d;
            skid_err_q  <= skid_err_d;
            cnt_q       <= cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: select/error are masked while idle so stale entries never leak.
    // ------------------------------------------------------------------------
    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_addr   = main_addr_q;
    assign out_tag    = main_tag_q;
    assign out_sel    = out_valid_q ? main_sel_q : '0;
    assign out_decerr = out_valid_q & main_err_q;
    assign decerr_cnt = cnt_q;

endmodule

// File: tb/tb_axi_addr_decode_slice.sv
// ----------------------------------------------------------------------------
// Bench for axi_addr_decode_slice: default-table instance checked through a
// scoreboard, plus a 2-region overlap instance and a 2-bit counter instance.
// ----------------------------------------------------------------------------
module tb_axi_addr_decode_slice;

    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- default-table instance ----------------
    logic        in_valid0, in_ready0, out_valid0, out_ready0, out_decerr0, cnt_clr0;
    logic [31:0] in_addr0, out_addr0;
    logic [3:0]  in_tag0, out_tag0;
    logic [7:0]  out_sel0;
    logic [15:0] decerr_cnt0;

    axi_addr_decode_slice u_dut0 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid0),
        .in_ready   (in_ready0),
        .in_addr    (in_addr0),
        .in_tag     (in_tag0),
        .out_valid  (out_valid0),
        .out_ready  (out_ready0),
        .out_addr   (out_addr0),
        .out_tag    (out_tag0),
        .out_sel    (out_sel0),
        .out_decerr (out_decerr0),
        .decerr_cnt (decerr_cnt0),
        .cnt_clr    (cnt_clr0)
    );

    // ---------------- two overlapping regions, second ends at 2^32 ----------------
    logic        in_valid1, in_ready1, out_valid1, out_decerr1;
    logic [31:0] in_addr1, out_addr1;
    logic [3:0]  out_tag1;
    logic [1:0]  out_sel1;
    logic [15:0] decerr_cnt1;

    axi_addr_decode_slice #(
        .NUM_SLAVES  (2),
        .REGION_BASE ({32'h0000_0800, 32'h0000_0000}),
        .REGION_SIZE ({32'hFFFF_F800, 32'h0000_1000})
    ) u_dut1 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid1),
        .in_ready   (in_ready1),
        .in_addr    (in_addr1),
        .in_tag     (4'h5),
        .out_valid  (out_valid1),
        .out_ready  (1'b1),
        .out_addr   (out_addr1),
        .out_tag    (out_tag1),
        .out_sel    (out_sel1),
        .out_decerr (out_decerr1),
        .decerr_cnt (decerr_cnt1),
        .cnt_clr    (1'b0)
    );

    // ---------------- 2-bit saturating counter instance ----------------
    logic        in_valid2, in_ready2, out_valid2, out_decerr2;
    logic [31:0] out_addr2;
    logic [3:0]  out_tag2;
    logic [7:0]  out_sel2;
    logic [1:0]  decerr_cnt2;

    axi_addr_decode_slice #(
        .CNT_W (2)
    ) u_dut2 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid2),
        .in_ready   (in_ready2),
        .in_addr    (32'hFFFF_FFFF),
        .in_tag     (4'h3),
        .out_valid  (out_valid2),
        .out_ready  (1'b1),
        .out_addr   (out_addr2),
        .out_tag    (out_tag2),
        .out_sel    (out_sel2),
        .out_decerr (out_decerr2),
        .decerr_cnt (decerr_cnt2),
        .cnt_clr    (1'b0)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int pops     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference decode of the default table: {sel[7:0], decerr}.
    function automatic logic [8:0] ref_dec(input logic [31:0] a);
        logic [63:0] lo;
        logic [63:0] sz;
        logic [63:0] ax;
        logic        found;
        logic [8:0]  r;
        ax    = {32'h0, a};
        found = 1'b0;
        r     = 9'b0_0000_0001;
        for (int i = 7; i >= 0; i--) begin
            case (i)
                0:       begin lo = 64'h8000_0000; sz = 64'h0800_0000; end
                7:       begin lo = 64'h0;         sz = 64'h4000;      end
                default: begin lo = 64'h8000 + 64'(6 - i) * 64'h10; sz = 64'h10; end
            endcase
            if (!found && sz != 0 && ax >= lo && ax < lo + sz) begin
                found = 1'b1;
                r     = {8'(1 << i), 1'b0};
            end
        end
        return r;
    endfunction

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  tag;
        logic [7:0]  sel;
        logic        dec;
    } exp_t;

    exp_t sb[$];

    logic        stall_v = 1'b0;
    logic [44:0] stall_pl;

    // Monitor for the default instance: pop/compare on output handshake,
    // push the expected result on input handshake.
    always @(negedge clk) begin
        exp_t       e;
        logic [8:0] d;
        if (rst) begin
            stall_v = 1'b0;
        end else begin
            if (!out_valid0) check("idle_sel_dec", {out_sel0, out_decerr0}, 64'h0);
            if (out_valid0 && stall_v)
                check("stall_stable", {out_addr0, out_tag0, out_sel0, out_decerr0}, stall_pl);
            stall_v  = out_valid0 && !out_ready0;
            stall_pl = {out_addr0, out_tag0, out_sel0, out_decerr0};
            if (out_valid0 && out_ready0) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_out", 64'h1, 64'h0);
                end else begin
                    e = sb.pop_front();
                    check("out_addr",   out_addr0,   e.addr);
                    check("out_tag",    out_tag0,    e.tag);
                    check("out_sel",    out_sel0,    e.sel);
                    check("out_decerr", out_decerr0, e.dec);
                    pops++;
                end
            end
            if (in_valid0 && in_ready0) begin
                d = ref_dec(in_addr0);
                e = '{addr: in_addr0, tag: in_tag0, sel: d[8:1], dec: d[0]};
                sb.push_back(e);
            end
        end
    end

    // Drive one request into the default instance; returns #1 after the
    // accepting edge.
    task automatic send(input logic [31:0] a, input logic [3:0] t);
        int unsigned n;
        n         = 0;
        in_valid0 = 1'b1;
        in_addr0  = a;
        in_tag0   = t;
        @(negedge clk);
        while (!in_ready0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready0) check("send_timeout", 64'h0, 64'h1);
        @(posedge clk);
        #1;
        in_valid0 = 1'b0;
    endtask

    task automatic probe1(input logic [31:0] a, input logic [1:0] s);
        check("ovr_ready", in_ready1, 1);
        in_valid1 = 1'b1;
        in_addr1  = a;
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        check("ovr_valid",  out_valid1,  1);
        check("ovr_sel",    out_sel1,    s);
        check("ovr_decerr", out_decerr1, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int unsigned n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("sb_drained", sb.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          c0;
        int          p0;
        logic [31:0] a;

        rst        = 1'b1;
        in_valid0  = 1'b0; in_addr0 = '0; in_tag0 = '0;
        out_ready0 = 1'b1; cnt_clr0 = 1'b0;
        in_valid1  = 1'b0; in_addr1 = '0;
        in_valid2  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_out_valid", out_valid0,  0);
        check("rst_in_ready",  in_ready0,   1);
        check("rst_out_sel",   out_sel0,    0);
        check("rst_decerr",    out_decerr0, 0);
        check("rst_out_addr",  out_addr0,   0);
        check("rst_out_tag",   out_tag0,    0);
        check("rst_cnt",       decerr_cnt0, 0);
        check("rst_cnt2",      decerr_cnt2, 0);

        // Overlap and top-of-space region
        probe1(32'h0000_0900, 2'b10);
        probe1(32'hFFFF_FFFF, 2'b10);
        probe1(32'h0000_0100, 2'b01);

        // Counter saturation with CNT_W=2: 5 DECERRs delivered
        in_valid2 = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        in_valid2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("cnt_saturate", decerr_cnt2, 3);

        // Single hits, one cycle latency
        out_ready0 = 1'b1;
        send(32'h0000_3FFC, 4'h1); check("lat_a", out_valid0, 1); @(posedge clk); #1;
        send(32'h0000_8014, 4'h2); check("lat_b", out_valid0, 1); @(posedge clk); #1;
        send(32'h8000_0000, 4'h3); check("lat_c", out_valid0, 1); @(posedge clk); #1;

        // Region boundaries that miss
        send(32'h0000_4000, 4'h4);
        send(32'h0000_8060, 4'h5);
        send(32'h8800_0000, 4'h6);
        send(32'hFFFF_FFFF, 4'h7);
        @(posedge clk); #1;
        check("cnt_four", decerr_cnt0, 4);
        send(32'h0000_4000, 4'h8);
        cnt_clr0 = 1'b1;
        @(posedge clk); #1;
        cnt_clr0 = 1'b0;
        check("cnt_clr_wins", decerr_cnt0, 0);
        send(32'h0000_8060, 4'h9);
        @(posedge clk); #1;
        check("cnt_after_clr", decerr_cnt0, 1);

        // Back-pressure: two accepted, third held
        out_ready0 = 1'b0;
        send(32'h0000_8004, 4'h1);
        send(32'h0000_8024, 4'h2);
        check("bp_full_ready", in_ready0, 0);
        fork
            send(32'h0000_8034, 4'h3);
            begin
                repeat (3) @(posedge clk);
                #1;
                check("bp_hold_ready", in_ready0,  0);
                check("bp_hold_valid", out_valid0, 1);
                out_ready0 = 1'b1;
            end
        join
        wait_drain();

        // Streaming at one request per cycle
        c0 = cyc;
        p0 = pops;
        for (int i = 0; i < 100; i++) begin
            a = $urandom;
            if (i % 3 == 1) a = 32'h0000_8000 + 32'(i % 24) * 32'h4;
            if (i % 3 == 2) a = {20'h0, 12'(i * 37)};
            send(a, 4'(i));
        end
        check("stream_cycles", cyc - c0, 100);
        @(posedge clk); #1;
        check("stream_outputs", pops - p0, 100);
        wait_drain();

        // Reset while full
        out_ready0 = 1'b0;
        send(32'h0000_0010, 4'hA);
        send(32'hFFFF_FFFF, 4'hB);
        check("rf_full", in_ready0, 0);
        rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        check("rf_out_valid", out_valid0,  0);
        check("rf_in_ready",  in_ready0,   1);
        check("rf_cnt",       decerr_cnt0, 0);
        check("rf_out_sel",   out_sel0,    0);
        check("rf_decerr",    out_decerr0, 0);
        out_ready0 = 1'b1;
        send(32'h0000_8014, 4'h9);
        check("rf_new_valid", out_valid0, 1);
        wait_drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
